// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator for 640x480@60 on a 25 MHz pixel
//                clock. Produces the pixel coordinate (xx, yy), the
//                active-video flag, the hsync/vsync pulses, a frame-start
//                strobe and a wrapping frame counter. Every output is a
//                register, and each flag is decoded from the coordinate
//                loaded on the same edge, so the flags always match xx/yy.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       Pclk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] xx,
    output logic [9:0] yy,
    output logic       aactive,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    // ------------------------------------------------------------------------
    // Derived raster geometry, sized to the 10-bit counters
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_h_last     = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_last     = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       c_sync_on    = (SYNC_POL != 0);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [9:0] r_xx;
    logic [9:0] r_yy;
    logic       r_aactive;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_start;
    logic [7:0] r_frame_count;
    // Set by reset; blocks the frame-count increment on the reset-release
    // wrap, which lands on (0,0) without a frame having been displayed.
    logic       r_first;

    // ------------------------------------------------------------------------
    // Next-position and flag decode
    // ------------------------------------------------------------------------
    logic       w_x_wrap;
    logic       w_y_wrap;
    logic [9:0] w_nx;
    logic [9:0] w_ny;
    logic       w_n_active;
    logic       w_n_hsync;
    logic       w_n_vsync;
    logic       w_n_frame_start;

    // Compute the coordinate the next enabled edge will load, and its flags
    always_comb begin
        w_x_wrap = (r_xx == c_h_last);
        w_y_wrap = (r_yy == c_v_last);

        w_nx = w_x_wrap ? 10'd0 : (r_xx + 10'd1);
        if (w_x_wrap) begin
            w_ny = w_y_wrap ? 10'd0 : (r_yy + 10'd1);
        end else begin
            w_ny = r_yy;
        end

        w_n_active      = (w_nx < c_h_active) && (w_ny < c_v_active);
        w_n_hsync       = ((w_nx >= c_hs_start) && (w_nx < c_hs_end)) ? c_sync_on : ~c_sync_on;
        w_n_vsync       = ((w_ny >= c_vs_start) && (w_ny < c_vs_end)) ? c_sync_on : ~c_sync_on;
        w_n_frame_start = (w_nx == 10'd0) && (w_ny == 10'd0);
    end

    // ------------------------------------------------------------------------
    // Sequential update: reset parks at the last pixel, enable advances,
    // stall holds everything except the frame-start strobe
    // ------------------------------------------------------------------------
    // Register the position, flags and frame counter
    always_ff @(posedge Pclk) begin
        if (!reset_n) begin
            r_xx          <= c_h_last;
            r_yy          <= c_v_last;
            r_aactive     <= 1'b0;
            r_hsync       <= ~c_sync_on;
            r_vsync       <= ~c_sync_on;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
            r_first       <= 1'b1;
        end else if (pix_en) begin
            r_xx          <= w_nx;
            r_yy          <= w_ny;
            r_aactive     <= w_n_active;
            r_hsync       <= w_n_hsync;
            r_vsync       <= w_n_vsync;
            r_frame_start <= w_n_frame_start;
            r_first       <= 1'b0;
            if (w_n_frame_start && !r_first) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end else begin
            // Stalled: the strobe must not repeat while the position holds
            r_frame_start <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs are driven straight from registers
    // ------------------------------------------------------------------------
    assign xx          = r_xx;
    assign yy          = r_yy;
    assign aactive     = r_aactive;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
